// File: rtl/fib_txrd_ctrl_pkg.sv
// Shared constants and state encoding for the TX read controller.
package fib_txrd_ctrl_pkg;

  localparam int unsigned BYTES_PER_WORD = 8;
  localparam int unsigned WORD_SHIFT     = $clog2(BYTES_PER_WORD);
  localparam int unsigned MOD_WIDTH      = 3;
  localparam int unsigned DEF_MAX_BCNT   = 9600;
  localparam int unsigned BUF_DEPTH      = 2;
  localparam int unsigned BUF_CNT_WIDTH  = $clog2(BUF_DEPTH + 1);

  typedef enum logic [4:0] {
    S_IDLE    = 5'b00001,
    S_LEN_RD  = 5'b00010,
    S_LEN_LAT = 5'b00100,
    S_SEND    = 5'b01000,
    S_DROP    = 5'b10000
  } state_t;

endpackage

// File: rtl/fib_tx_skidbuf.sv
// Two-entry in-order output buffer; head entry drives the MAC directly.
module fib_tx_skidbuf
  import fib_txrd_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 69
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     valid,
  output logic [WIDTH-1:0]         head,
  output logic [BUF_CNT_WIDTH-1:0] count
);

  logic [WIDTH-1:0] tail;
  logic             pop_ok;

  assign valid  = (count != '0);
  assign pop_ok = pop && valid;

  // Head is zeroed when the buffer drains so idle outputs read as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      unique case ({push, pop_ok})
        2'b10: begin
          if (count == '0) head <= push_data;
          else             tail <= push_data;
          count <= count + BUF_CNT_WIDTH'(1);
        end
        2'b01: begin
          head  <= (count == BUF_CNT_WIDTH'(2)) ? tail : '0;
          count <= count - BUF_CNT_WIDTH'(1);
        end
        2'b11: begin
          if (count == BUF_CNT_WIDTH'(1)) begin
            head <= push_data;
          end else begin
            head <= tail;
            tail <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fib_txrd_ctrl.sv
// Reads a byte count, then streams or discards that frame's data words to the MAC.
module fib_txrd_ctrl
  import fib_txrd_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned BCNT_WIDTH = 32,
  parameter int unsigned MAX_BCNT   = DEF_MAX_BCNT
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  txwbcnt_rdreq,
  input  logic [BCNT_WIDTH-1:0] txwbcnt_rdata,
  input  logic                  txwbcnt_rdempty,
  output logic                  txdata_rdreq,
  input  logic [DATA_WIDTH-1:0] txdata_rdata,
  input  logic                  txdata_rdempty,
  output logic [DATA_WIDTH-1:0] mac_tx_data,
  output logic                  mac_tx_valid,
  input  logic                  mac_tx_ready,
  output logic                  mac_tx_sop,
  output logic                  mac_tx_eop,
  output logic [MOD_WIDTH-1:0]  mac_tx_mod,
  output logic                  tx_drop,
  output logic [31:0]           tx_frame_cnt
);

  localparam int unsigned SUM_WIDTH = BCNT_WIDTH + 1;
  localparam int unsigned WL_WIDTH  = BCNT_WIDTH - WORD_SHIFT + 1;
  localparam int unsigned BUF_WIDTH = DATA_WIDTH + 2 + MOD_WIDTH;

  state_t                   state;
  logic [WL_WIDTH-1:0]      words_left;
  logic [MOD_WIDTH-1:0]     bcnt_lo;
  logic                     first;
  logic                     inflight;
  logic                     push_sop;
  logic                     push_eop;
  logic [MOD_WIDTH-1:0]     push_mod;
  logic                     buf_valid;
  logic [BUF_WIDTH-1:0]     buf_head;
  logic [BUF_CNT_WIDTH-1:0] buf_count;
  logic                     pop;
  logic [2:0]               occ;

  assign pop = buf_valid && mac_tx_ready;

  // Occupancy counts the word leaving this cycle as gone, which keeps one word per cycle flowing.
  assign occ = 3'(buf_count) + 3'(inflight) - 3'(pop);

  assign txdata_rdreq = !reset && (words_left != '0) && !txdata_rdempty &&
                        (((state == S_SEND) && (occ < 3'd2)) || (state == S_DROP));

  fib_tx_skidbuf #(
    .WIDTH(BUF_WIDTH)
  ) u_skidbuf (
    .clk      (clk),
    .reset    (reset),
    .push     (inflight),
    .push_data({txdata_rdata, push_sop, push_eop, push_mod}),
    .pop      (pop),
    .valid    (buf_valid),
    .head     (buf_head),
    .count    (buf_count)
  );

  assign mac_tx_valid = buf_valid;
  assign {mac_tx_data, mac_tx_sop, mac_tx_eop, mac_tx_mod} = buf_head;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      txwbcnt_rdreq <= 1'b0;
      tx_drop       <= 1'b0;
      words_left    <= '0;
      bcnt_lo       <= '0;
      first         <= 1'b0;
      inflight      <= 1'b0;
      push_sop      <= 1'b0;
      push_eop      <= 1'b0;
      push_mod      <= '0;
      tx_frame_cnt  <= '0;
    end else begin
      txwbcnt_rdreq <= 1'b0;
      tx_drop       <= 1'b0;
      inflight      <= txdata_rdreq && (state == S_SEND);

      // Frame marking travels with the read so it lines up with the returning word.
      if (txdata_rdreq) begin
        words_left <= words_left - WL_WIDTH'(1);
        first      <= 1'b0;
        push_sop   <= first;
        push_eop   <= (words_left == WL_WIDTH'(1));
        push_mod   <= (words_left == WL_WIDTH'(1)) ? bcnt_lo : '0;
      end

      if (pop && mac_tx_eop) tx_frame_cnt <= tx_frame_cnt + 32'd1;

      unique case (state)
        S_IDLE: begin
          if (!txwbcnt_rdempty) begin
            txwbcnt_rdreq <= 1'b1;
            state         <= S_LEN_RD;
          end
        end
        S_LEN_RD: state <= S_LEN_LAT;
        S_LEN_LAT: begin
          bcnt_lo    <= txwbcnt_rdata[MOD_WIDTH-1:0];
          words_left <= WL_WIDTH'((SUM_WIDTH'(txwbcnt_rdata) +
                                   SUM_WIDTH'(BYTES_PER_WORD - 1)) >> WORD_SHIFT);
          first      <= 1'b1;
          if (txwbcnt_rdata == '0) begin
            tx_drop <= 1'b1;
            state   <= S_IDLE;
          end else if (txwbcnt_rdata > BCNT_WIDTH'(MAX_BCNT)) begin
            state <= S_DROP;
          end else begin
            state <= S_SEND;
          end
        end
        S_SEND: begin
          if (pop && mac_tx_eop) state <= S_IDLE;
        end
        S_DROP: begin
          if (words_left == '0) begin
            tx_drop <= 1'b1;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_txrd_ctrl.sv
// Bench for fib_txrd_ctrl: FIFO models, MAC sink and a frame-level reference model.
module tb_fib_txrd_ctrl;

  localparam int unsigned MAXB = 9600;

  logic        clk = 1'b0;
  logic        reset;
  logic        txwbcnt_rdreq;
  logic [31:0] txwbcnt_rdata;
  logic        txwbcnt_rdempty;
  logic        txdata_rdreq;
  logic [63:0] txdata_rdata;
  logic        txdata_rdempty;
  logic [63:0] mac_tx_data;
  logic        mac_tx_valid;
  logic        mac_tx_ready;
  logic        mac_tx_sop;
  logic        mac_tx_eop;
  logic [2:0]  mac_tx_mod;
  logic        tx_drop;
  logic [31:0] tx_frame_cnt;

  always #5 clk = ~clk;

  fib_txrd_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .txwbcnt_rdreq  (txwbcnt_rdreq),
    .txwbcnt_rdata  (txwbcnt_rdata),
    .txwbcnt_rdempty(txwbcnt_rdempty),
    .txdata_rdreq   (txdata_rdreq),
    .txdata_rdata   (txdata_rdata),
    .txdata_rdempty (txdata_rdempty),
    .mac_tx_data    (mac_tx_data),
    .mac_tx_valid   (mac_tx_valid),
    .mac_tx_ready   (mac_tx_ready),
    .mac_tx_sop     (mac_tx_sop),
    .mac_tx_eop     (mac_tx_eop),
    .mac_tx_mod     (mac_tx_mod),
    .tx_drop        (tx_drop),
    .tx_frame_cnt   (tx_frame_cnt)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pops_total = 0, drops_total = 0, exp_pops = 0, exp_drops = 0, exp_frames = 0;
  int viol_rd = 0, viol_stable = 0;
  int hold_cnt = 0, hold_trigger = -1, rmode = 0;
  logic        prev_stall = 1'b0;
  logic [68:0] prev_word = '0;

  logic [31:0] lq[$];
  logic [63:0] dq[$];
  logic [63:0] exp_data[$], obs_data[$];
  logic [4:0]  exp_tag[$], obs_tag[$];
  int          obs_cyc[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_empties();
    txwbcnt_rdempty = (lq.size() == 0);
    txdata_rdempty  = (hold_cnt > 0) || (dq.size() == 0);
  endtask

  // Reference model: a frame is ceil(bcnt/8) words; sop first, eop last with mod=bcnt%8.
  task automatic add_frame(input int unsigned bcnt);
    int unsigned n;
    logic [63:0] w;
    n = (bcnt + 7) / 8;
    lq.push_back(bcnt);
    for (int unsigned i = 0; i < n; i++) begin
      w = {$urandom, $urandom};
      dq.push_back(w);
      if (bcnt <= MAXB) begin
        exp_data.push_back(w);
        exp_tag.push_back({(i == 0), (i == n - 1), (i == n - 1) ? 3'(bcnt % 8) : 3'd0});
      end
    end
    if (bcnt == 0 || bcnt > MAXB) exp_drops++;
    else exp_frames++;
    exp_pops += int'(n);
    set_empties();
  endtask

  // One clock: observe at the falling edge, service FIFO pops just after the rising edge.
  task automatic step();
    logic lrd, drd;
    @(negedge clk);
    cyc++;
    if (txdata_rdreq && txdata_rdempty) viol_rd++;
    if (txwbcnt_rdreq && txwbcnt_rdempty) viol_rd++;
    if (prev_stall && (!mac_tx_valid ||
        {mac_tx_data, mac_tx_sop, mac_tx_eop, mac_tx_mod} != prev_word)) viol_stable++;
    prev_stall = mac_tx_valid && !mac_tx_ready;
    prev_word  = {mac_tx_data, mac_tx_sop, mac_tx_eop, mac_tx_mod};
    if (mac_tx_valid && mac_tx_ready) begin
      obs_data.push_back(mac_tx_data);
      obs_tag.push_back({mac_tx_sop, mac_tx_eop, mac_tx_mod});
      obs_cyc.push_back(cyc);
    end
    if (tx_drop) drops_total++;
    lrd = txwbcnt_rdreq;
    drd = txdata_rdreq;
    @(posedge clk);
    #1;
    if (hold_cnt > 0) hold_cnt--;
    if (lrd && lq.size() > 0) txwbcnt_rdata = lq.pop_front();
    if (drd && dq.size() > 0) begin
      txdata_rdata = dq.pop_front();
      pops_total++;
      if (pops_total == hold_trigger) begin
        hold_cnt     = 10;
        hold_trigger = -1;
      end
    end
    set_empties();
    case (rmode)
      0:       mac_tx_ready = 1'b1;
      1:       mac_tx_ready = ~mac_tx_ready;
      default: mac_tx_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic run_idle(input int budget);
    int quiet = 0;
    int n = 0;
    while (quiet < 6 && n < budget) begin
      step();
      n++;
      if (lq.size() == 0 && dq.size() == 0 && !mac_tx_valid && !txdata_rdreq &&
          !txwbcnt_rdreq && hold_cnt == 0) quiet++;
      else quiet = 0;
    end
    chk("run_timeout", 64'(n < budget), 64'd1);
  endtask

  task automatic compare_frames(input string tag);
    chk({tag, "_nwords"}, 64'(obs_data.size()), 64'(exp_data.size()));
    while (obs_data.size() > 0 && exp_data.size() > 0) begin
      chk({tag, "_data"}, obs_data.pop_front(), exp_data.pop_front());
      chk({tag, "_tag"}, 64'(obs_tag.pop_front()), 64'(exp_tag.pop_front()));
    end
    obs_data.delete();
    obs_tag.delete();
    obs_cyc.delete();
    exp_data.delete();
    exp_tag.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 64'(mac_tx_valid), 64'd0);
    chk({tag, "_sop"}, 64'(mac_tx_sop), 64'd0);
    chk({tag, "_eop"}, 64'(mac_tx_eop), 64'd0);
    chk({tag, "_mod"}, 64'(mac_tx_mod), 64'd0);
    chk({tag, "_data"}, mac_tx_data, 64'd0);
    chk({tag, "_drop"}, 64'(tx_drop), 64'd0);
    chk({tag, "_fcnt"}, 64'(tx_frame_cnt), 64'd0);
    chk({tag, "_lrdreq"}, 64'(txwbcnt_rdreq), 64'd0);
    chk({tag, "_drdreq"}, 64'(txdata_rdreq), 64'd0);
  endtask

  initial begin
    int base_pops, base_drops, span, gap, waited;
    int unsigned r, bcnt;
    reset           = 1'b1;
    mac_tx_ready    = 1'b1;
    txwbcnt_rdata   = '0;
    txdata_rdata    = '0;
    txwbcnt_rdempty = 1'b1;
    txdata_rdempty  = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk_reset_outputs("rst");
    reset = 1'b0;

    // 64 bytes at full rate
    rmode = 0;
    add_frame(64);
    run_idle(200);
    span = (obs_cyc.size() == 8) ? obs_cyc[7] - obs_cyc[0] : -1;
    chk("b64_span", 64'(span), 64'd7);
    compare_frames("b64");
    chk("b64_fcnt", 64'(tx_frame_cnt), 64'(exp_frames));

    // 61 bytes then a single-word frame
    add_frame(61);
    add_frame(3);
    run_idle(200);
    compare_frames("b61_b3");
    chk("b61_fcnt", 64'(tx_frame_cnt), 64'(exp_frames));

    // 100 bytes with ready toggling
    rmode = 1;
    add_frame(100);
    run_idle(300);
    compare_frames("b100");
    chk("b100_fcnt", 64'(tx_frame_cnt), 64'(exp_frames));

    // zero-length and oversize frames are discarded
    rmode      = 0;
    base_pops  = pops_total;
    base_drops = drops_total;
    add_frame(0);
    add_frame(9608);
    run_idle(5000);
    chk("drop_pops", 64'(pops_total - base_pops), 64'd1201);
    chk("drop_pulses", 64'(drops_total - base_drops), 64'd2);
    compare_frames("drop");
    chk("drop_fcnt", 64'(tx_frame_cnt), 64'(exp_frames));

    // data FIFO runs dry after word 3 of a 40-byte frame
    hold_trigger = pops_total + 3;
    add_frame(40);
    run_idle(300);
    gap = (obs_cyc.size() == 5) ? obs_cyc[3] - obs_cyc[2] : 0;
    chk("hold_gap_ge10", 64'(gap >= 10), 64'd1);
    compare_frames("b40");
    chk("b40_fcnt", 64'(tx_frame_cnt), 64'(exp_frames));

    // random frames with random backpressure
    rmode = 2;
    for (int i = 0; i < 12; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      bcnt = 0;
      else if (r == 1) bcnt = $urandom_range(9601, 9700);
      else             bcnt = $urandom_range(1, 300);
      add_frame(bcnt);
    end
    run_idle(40000);
    compare_frames("rand");
    chk("rand_fcnt", 64'(tx_frame_cnt), 64'(exp_frames));
    chk("total_pops", 64'(pops_total), 64'(exp_pops));
    chk("total_drops", 64'(drops_total), 64'(exp_drops));

    // reset while word 2 of a 64-byte frame is on the bus
    rmode = 0;
    mac_tx_ready = 1'b1;
    add_frame(64);
    waited = 0;
    while (obs_data.size() < 1 && waited < 50) begin
      step();
      waited++;
    end
    chk("rst_wait", 64'(waited < 50), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    lq.delete();
    dq.delete();
    hold_cnt      = 0;
    txwbcnt_rdata = '0;
    txdata_rdata  = '0;
    set_empties();
    exp_frames = 0;
    obs_data.delete();
    obs_tag.delete();
    obs_cyc.delete();
    exp_data.delete();
    exp_tag.delete();
    @(negedge clk);
    chk_reset_outputs("midrst");
    prev_stall = 1'b0;

    add_frame(16);
    run_idle(200);
    compare_frames("post_rst");
    chk("post_rst_fcnt", 64'(tx_frame_cnt), 64'd1);

    chk("rdreq_when_empty", 64'(viol_rd), 64'd0);
    chk("stall_stability", 64'(viol_stable), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
